// File: rtl/mem_pool_read_arbiter.sv
// rtl/mem_pool_read_arbiter.sv - round-robin read scheduler from requesters to image bram groups
//
// Ports:
//   clk, rst_p           : rising-edge clock, synchronous active-high reset
//   req_group_id_i       : one-hot target group per requester
//   req_bank_en_i        : per-requester bank enables (nonzero = request valid)
//   req_addr_i           : per-requester per-bank addresses
//   req_addr_ready_o     : request granted this cycle
//   req_data_valid_o     : return FIFO head valid
//   req_data_o           : return FIFO head data
//   req_data_ready_i     : consumer pops the FIFO head
//   grp_read_bank_en_o   : bank enables driven to each bram group
//   grp_read_addr_o      : addresses driven to each bram group
//   grp_read_data_i      : read data from each bram group
//   illegal_grp_o        : valid request with zero or multi-hot group id
module mem_pool_read_arbiter #(
  parameter int REQ_NUM         = 3,
  parameter int IMG_GRP_NUM     = 3,
  parameter int ROW_PARA        = 4,
  parameter int CHL_PARA        = 8,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int BANK_UNIT_WIDTH = 8,
  parameter int RD_LATENCY      = 2,
  parameter int FIFO_DEPTH      = 4,
  localparam int DW = ROW_PARA * CHL_PARA * BANK_UNIT_WIDTH,
  localparam int AW = ROW_PARA * BANK_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_p,
  input  logic [REQ_NUM*IMG_GRP_NUM-1:0]  req_group_id_i,
  input  logic [REQ_NUM*ROW_PARA-1:0]     req_bank_en_i,
  input  logic [REQ_NUM*AW-1:0]           req_addr_i,
  output logic [REQ_NUM-1:0]              req_addr_ready_o,
  output logic [REQ_NUM-1:0]              req_data_valid_o,
  output logic [REQ_NUM*DW-1:0]           req_data_o,
  input  logic [REQ_NUM-1:0]              req_data_ready_i,
  output logic [IMG_GRP_NUM*ROW_PARA-1:0] grp_read_bank_en_o,
  output logic [IMG_GRP_NUM*AW-1:0]       grp_read_addr_o,
  input  logic [IMG_GRP_NUM*DW-1:0]       grp_read_data_i,
  output logic [REQ_NUM-1:0]              illegal_grp_o
);

  localparam int REQ_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CRD_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LANE_W = CHL_PARA * BANK_UNIT_WIDTH;

  localparam logic [REQ_W-1:0] REQ_ONE   = 1;
  localparam logic [PTR_W:0]   PTR_ONE   = 1;
  localparam logic [CRD_W-1:0] CRD_ONE   = 1;
  localparam logic [CRD_W-1:0] CRD_RESET = CRD_W'(FIFO_DEPTH);

  // Unpacked request views
  logic [IMG_GRP_NUM-1:0] req_gid [REQ_NUM];
  logic [ROW_PARA-1:0]    req_ben [REQ_NUM];
  logic [AW-1:0]          req_adr [REQ_NUM];
  logic [REQ_NUM-1:0]     req_valid;
  logic [REQ_NUM-1:0]     gid_onehot;
  logic [REQ_NUM-1:0]     eligible;

  // Arbitration state
  logic [REQ_W-1:0]       rr_ptr     [IMG_GRP_NUM];
  logic [REQ_W-1:0]       grp_winner [IMG_GRP_NUM];
  logic [IMG_GRP_NUM-1:0] grp_grant;
  logic [CRD_W-1:0]       credit     [REQ_NUM];

  // In-flight tag pipeline, one slot per group: the slot index is the group id
  logic                   tag_vld [RD_LATENCY][IMG_GRP_NUM];
  logic [REQ_W-1:0]       tag_req [RD_LATENCY][IMG_GRP_NUM];
  logic [ROW_PARA-1:0]    tag_ben [RD_LATENCY][IMG_GRP_NUM];

  // Return path
  logic [DW-1:0]          grp_ret   [IMG_GRP_NUM];
  logic [REQ_NUM-1:0]     fifo_push;
  logic [DW-1:0]          push_data [REQ_NUM];
  logic [REQ_NUM-1:0]     fifo_pop;
  logic [REQ_NUM-1:0]     fifo_empty;
  logic [DW-1:0]          fifo_mem  [REQ_NUM][FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr    [REQ_NUM];
  logic [PTR_W:0]         rd_ptr    [REQ_NUM];

  always_comb begin
    req_valid     = '0;
    gid_onehot    = '0;
    eligible      = '0;
    illegal_grp_o = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      req_gid[r]    = req_group_id_i[r*IMG_GRP_NUM +: IMG_GRP_NUM];
      req_ben[r]    = req_bank_en_i[r*ROW_PARA +: ROW_PARA];
      req_adr[r]    = req_addr_i[r*AW +: AW];
      req_valid[r]  = |req_ben[r];
      gid_onehot[r] = (req_gid[r] != '0) && ((req_gid[r] & (req_gid[r] - 1'b1)) == '0);
      // Reset gating keeps every output quiet while rst_p is high
      eligible[r]      = !rst_p && req_valid[r] && gid_onehot[r] && (credit[r] != '0);
      illegal_grp_o[r] = !rst_p && req_valid[r] && !gid_onehot[r];
    end
  end

  // Round-robin search per group, starting at rr_ptr and wrapping
  always_comb begin : arb_comb
    int idx;
    idx       = 0;
    grp_grant = '0;
    for (int g = 0; g < IMG_GRP_NUM; g++) begin
      grp_winner[g] = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
        idx = int'(rr_ptr[g]) + i;
        if (idx >= REQ_NUM) idx = idx - REQ_NUM;
        if (!grp_grant[g] && eligible[idx] && req_gid[idx][g]) begin
          grp_grant[g]  = 1'b1;
          grp_winner[g] = REQ_W'(idx);
        end
      end
    end
  end

  // A requester targets exactly one group, so it wins at most one grant per cycle
  always_comb begin
    req_addr_ready_o   = '0;
    grp_read_bank_en_o = '0;
    grp_read_addr_o    = '0;
    for (int g = 0; g < IMG_GRP_NUM; g++) begin
      if (grp_grant[g]) begin
        grp_read_bank_en_o[g*ROW_PARA +: ROW_PARA] = req_ben[grp_winner[g]];
        grp_read_addr_o[g*AW +: AW]                = req_adr[grp_winner[g]];
        for (int r = 0; r < REQ_NUM; r++) begin
          if (int'(grp_winner[g]) == r) req_addr_ready_o[r] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      for (int g = 0; g < IMG_GRP_NUM; g++) rr_ptr[g] <= '0;
    end else begin
      for (int g = 0; g < IMG_GRP_NUM; g++) begin
        if (grp_grant[g]) begin
          rr_ptr[g] <= (int'(grp_winner[g]) == REQ_NUM - 1) ? '0 : grp_winner[g] + REQ_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        for (int g = 0; g < IMG_GRP_NUM; g++) begin
          tag_vld[s][g] <= 1'b0;
          tag_req[s][g] <= '0;
          tag_ben[s][g] <= '0;
        end
      end
    end else begin
      for (int g = 0; g < IMG_GRP_NUM; g++) begin
        tag_vld[0][g] <= grp_grant[g];
        tag_req[0][g] <= grp_winner[g];
        tag_ben[0][g] <= grp_read_bank_en_o[g*ROW_PARA +: ROW_PARA];
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        for (int g = 0; g < IMG_GRP_NUM; g++) begin
          tag_vld[s][g] <= tag_vld[s-1][g];
          tag_req[s][g] <= tag_req[s-1][g];
          tag_ben[s][g] <= tag_ben[s-1][g];
        end
      end
    end
  end

  // The last tag stage lines up with the bram data; disabled bank lanes are zeroed
  always_comb begin
    fifo_push = '0;
    for (int g = 0; g < IMG_GRP_NUM; g++) begin
      grp_ret[g] = grp_read_data_i[g*DW +: DW];
      for (int b = 0; b < ROW_PARA; b++) begin
        if (!tag_ben[RD_LATENCY-1][g][b]) grp_ret[g][b*LANE_W +: LANE_W] = '0;
      end
    end
    for (int r = 0; r < REQ_NUM; r++) begin
      push_data[r] = '0;
      for (int g = 0; g < IMG_GRP_NUM; g++) begin
        if (tag_vld[RD_LATENCY-1][g] && int'(tag_req[RD_LATENCY-1][g]) == r) begin
          fifo_push[r] = 1'b1;
          push_data[r] = grp_ret[g];
        end
      end
    end
  end

  always_comb begin
    req_data_valid_o = '0;
    req_data_o       = '0;
    fifo_pop         = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      fifo_empty[r]       = (wr_ptr[r] == rd_ptr[r]);
      req_data_valid_o[r] = !rst_p && !fifo_empty[r];
      fifo_pop[r]         = req_data_valid_o[r] && req_data_ready_i[r];
      if (req_data_valid_o[r]) req_data_o[r*DW +: DW] = fifo_mem[r][rd_ptr[r][PTR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < REQ_NUM; r++) begin
      if (!rst_p && fifo_push[r]) fifo_mem[r][wr_ptr[r][PTR_W-1:0]] <= push_data[r];
    end
  end

  // Credits count free FIFO slots including in-flight reads, so a push never finds the FIFO full
  always_ff @(posedge clk) begin
    if (rst_p) begin
      for (int r = 0; r < REQ_NUM; r++) begin
        wr_ptr[r] <= '0;
        rd_ptr[r] <= '0;
        credit[r] <= CRD_RESET;
      end
    end else begin
      for (int r = 0; r < REQ_NUM; r++) begin
        if (fifo_push[r]) wr_ptr[r] <= wr_ptr[r] + PTR_ONE;
        if (fifo_pop[r])  rd_ptr[r] <= rd_ptr[r] + PTR_ONE;
        if (req_addr_ready_o[r] && !fifo_pop[r])      credit[r] <= credit[r] - CRD_ONE;
        else if (!req_addr_ready_o[r] && fifo_pop[r]) credit[r] <= credit[r] + CRD_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mem_pool_read_arbiter.sv
// tb/tb_mem_pool_read_arbiter.sv - directed vector bench for mem_pool_read_arbiter
module tb_mem_pool_read_arbiter;

  localparam int RN = 3;
  localparam int GN = 3;
  localparam int DW = 256;
  localparam int AW = 48;

  localparam logic [2:0] G0 = 3'b001;
  localparam logic [2:0] G1 = 3'b010;
  localparam logic [2:0] G2 = 3'b100;
  localparam logic [3:0] BF = 4'b1111;

  logic             clk;
  logic             rst_p;
  logic [RN*GN-1:0] req_group_id;
  logic [RN*4-1:0]  req_bank_en;
  logic [RN*AW-1:0] req_addr;
  logic [RN-1:0]    req_addr_ready;
  logic [RN-1:0]    req_data_valid;
  logic [RN*DW-1:0] req_data;
  logic [RN-1:0]    req_data_ready;
  logic [GN*4-1:0]  grp_ben;
  logic [GN*AW-1:0] grp_addr;
  logic [GN*DW-1:0] grp_data;
  logic [RN-1:0]    illegal_grp;

  int n_vec  = 0;
  int n_miss = 0;
  logic [DW-1:0] exp_q [RN][$];
  int out_cnt [RN] = '{0, 0, 0};

  mem_pool_read_arbiter dut (
    .clk                (clk),
    .rst_p              (rst_p),
    .req_group_id_i     (req_group_id),
    .req_bank_en_i      (req_bank_en),
    .req_addr_i         (req_addr),
    .req_addr_ready_o   (req_addr_ready),
    .req_data_valid_o   (req_data_valid),
    .req_data_o         (req_data),
    .req_data_ready_i   (req_data_ready),
    .grp_read_bank_en_o (grp_ben),
    .grp_read_addr_o    (grp_addr),
    .grp_read_data_i    (grp_data),
    .illegal_grp_o      (illegal_grp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bram content: unit c of bank b = low byte of that bank's address + 16*c + 64*g + 1
  function automatic logic [DW-1:0] bram_word(input int g, input logic [AW-1:0] a, input logic [3:0] ben);
    logic [DW-1:0] w;
    logic [7:0] v;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 8; c++) begin
        v = a[b*12 +: 8] + 8'(c * 16) + 8'(g * 64) + 8'd1;
        if (ben[b]) w[(b*8 + c)*8 +: 8] = v;
      end
    end
    return w;
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int seed);
    logic [AW-1:0] a;
    for (int b = 0; b < 4; b++) a[b*12 +: 12] = 12'(seed * 4 + b);
    return a;
  endfunction

  // Two-cycle bram read latency model
  logic [AW-1:0] bram_a1 [GN];
  logic [AW-1:0] bram_a2 [GN];
  always @(posedge clk) begin
    for (int g = 0; g < GN; g++) begin
      bram_a1[g] <= grp_addr[g*AW +: AW];
      bram_a2[g] <= bram_a1[g];
    end
  end
  always_comb begin
    grp_data = '0;
    for (int g = 0; g < GN; g++) grp_data[g*DW +: DW] = bram_word(g, bram_a2[g], BF);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every popped word must match the oldest expected entry of that requester
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      for (int r = 0; r < RN; r++) begin
        if (rst_p) begin
          out_cnt[r] = 0;
        end else begin
          if (req_data_valid[r] && req_data_ready[r]) begin
            out_cnt[r] = out_cnt[r] - 1;
            if (exp_q[r].size() == 0) begin
              n_vec++;
              n_miss++;
              $display("FAIL r%0d data: got unexpected %0h, nothing pending", r, req_data[r*DW +: DW]);
            end else begin
              e = exp_q[r].pop_front();
              chk($sformatf("r%0d data", r), req_data[r*DW +: DW], e);
            end
          end
          if (req_addr_ready[r]) begin
            out_cnt[r] = out_cnt[r] + 1;
            n_vec++;
            if (out_cnt[r] > 4) begin
              n_miss++;
              $display("FAIL r%0d overflow: outstanding %0d required <= 4", r, out_cnt[r]);
            end
          end
        end
      end
    end
  end

  task automatic clear_req();
    req_group_id = '0;
    req_bank_en  = '0;
    req_addr     = '0;
  endtask

  task automatic set_req(input int r, input logic [2:0] gid, input logic [3:0] ben, input int seed);
    req_group_id[r*GN +: GN] = gid;
    req_bank_en[r*4 +: 4]    = ben;
    req_addr[r*AW +: AW]     = mk_addr(seed);
  endtask

  // Apply current inputs for one cycle and check the grant-side outputs
  task automatic step(input logic [2:0] exp_ready, input logic [2:0] exp_ill, input string name);
    logic [GN*4-1:0]  eben;
    logic [GN*AW-1:0] eadr;
    int gi [RN];
    eben = '0;
    eadr = '0;
    for (int r = 0; r < RN; r++) begin
      gi[r] = 0;
      for (int g = 0; g < GN; g++) if (req_group_id[r*GN + g]) gi[r] = g;
      if (exp_ready[r]) begin
        eben[gi[r]*4 +: 4]   = req_bank_en[r*4 +: 4];
        eadr[gi[r]*AW +: AW] = req_addr[r*AW +: AW];
      end
    end
    @(negedge clk);
    chk({name, " addr_ready"}, DW'(req_addr_ready), DW'(exp_ready));
    chk({name, " illegal"}, DW'(illegal_grp), DW'(exp_ill));
    chk({name, " grp_ben"}, DW'(grp_ben), DW'(eben));
    chk({name, " grp_addr"}, DW'(grp_addr), DW'(eadr));
    for (int r = 0; r < RN; r++) begin
      if (exp_ready[r]) exp_q[r].push_back(bram_word(gi[r], req_addr[r*AW +: AW], req_bank_en[r*4 +: 4]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input logic [2:0] exp_valid, input string name);
    @(negedge clk);
    chk({name, " data_valid"}, DW'(req_data_valid), DW'(exp_valid));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n, input string name);
    clear_req();
    repeat (n) @(posedge clk);
    #1;
    for (int r = 0; r < RN; r++) chk($sformatf("%s r%0d pending", name, r), DW'(exp_q[r].size()), '0);
  endtask

  task automatic do_reset();
    rst_p = 1'b1;
    @(posedge clk);
    #1;
    rst_p = 1'b0;
    for (int r = 0; r < RN; r++) exp_q[r].delete();
  endtask

  typedef struct {
    logic [8:0]  gid;
    logic [11:0] ben;
    logic [2:0]  exp_ready;
    logic [2:0]  exp_ill;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{9'd0,              12'd0,                      3'b000, 3'b000};
    vecs[1]  = '{{3'b0, 3'b0, G0},  {4'h0, 4'h0, BF},           3'b001, 3'b000};
    vecs[2]  = '{{3'b0, G2, G0},    {4'h0, BF, BF},             3'b011, 3'b000};
    vecs[3]  = '{{G0, G0, G0},      {BF, BF, BF},               3'b010, 3'b000};
    vecs[4]  = '{{G0, G0, G0},      {BF, BF, BF},               3'b100, 3'b000};
    vecs[5]  = '{{G0, G0, G0},      {BF, BF, BF},               3'b001, 3'b000};
    vecs[6]  = '{{3'b0, 3'b011, G1}, {4'h0, BF, BF},            3'b001, 3'b010};
    vecs[7]  = '{{3'b000, G1, G2},  {4'b0011, BF, BF},          3'b011, 3'b100};
    vecs[8]  = '{{3'b111, G2, G2},  {4'h0, BF, BF},             3'b010, 3'b000};
    vecs[9]  = '{{G2, G2, G2},      {BF, BF, BF},               3'b100, 3'b000};
    vecs[10] = '{{G0, G1, G1},      {BF, BF, BF},               3'b101, 3'b000};
    vecs[11] = '{{3'b0, G1, G0},    {4'h0, 4'b1000, 4'b0101},   3'b011, 3'b000};
    vecs[12] = '{9'd0,              12'd0,                      3'b000, 3'b000};

    rst_p          = 1'b1;
    req_data_ready = 3'b111;
    clear_req();
    @(posedge clk);
    #1;
    // Requests during reset must see no grant and no illegal flag
    set_req(0, G0, BF, 1);
    set_req(1, 3'b011, BF, 2);
    step(3'b000, 3'b000, "reset");
    chk("reset data_valid", DW'(req_data_valid), '0);
    rst_p = 1'b0;
    clear_req();

    for (int i = 0; i < 13; i++) begin
      req_group_id = vecs[i].gid;
      req_bank_en  = vecs[i].ben;
      for (int r = 0; r < RN; r++) req_addr[r*AW +: AW] = mk_addr(i * 3 + r + 1);
      step(vecs[i].exp_ready, vecs[i].exp_ill, $sformatf("vec%0d", i));
    end
    drain(6, "table");

    // Single request latency: valid exactly three cycles after the grant
    set_req(0, G0, BF, 50);
    step(3'b001, 3'b000, "single");
    clear_req();
    idle_chk(3'b000, "single t1");
    idle_chk(3'b000, "single t2");
    idle_chk(3'b001, "single t3");
    idle_chk(3'b000, "single t4");

    do_reset();

    // Contention on group 1 from a freshly reset pointer
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < RN; r++) set_req(r, G1, BF, 60 + k * 3 + r);
      step(3'(1 << (k % 3)), 3'b000, $sformatf("contend%0d", k));
    end
    drain(6, "contend");

    // Independent groups granted in the same cycle
    set_req(0, G0, BF, 80);
    set_req(1, G2, BF, 81);
    step(3'b011, 3'b000, "parallel");
    clear_req();
    idle_chk(3'b000, "parallel t1");
    idle_chk(3'b000, "parallel t2");
    idle_chk(3'b011, "parallel t3");
    idle_chk(3'b000, "parallel t4");

    // Backpressure: credits stop grants after four, one pop frees exactly one more
    req_data_ready = 3'b110;
    for (int k = 0; k < 4; k++) begin
      set_req(0, G0, BF, 90 + k);
      step(3'b001, 3'b000, $sformatf("bp grant%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      set_req(0, G0, BF, 100 + k);
      step(3'b000, 3'b000, $sformatf("bp stall%0d", k));
    end
    req_data_ready = 3'b111;
    set_req(0, G0, BF, 103);
    step(3'b000, 3'b000, "bp pop");
    req_data_ready = 3'b110;
    set_req(0, G0, BF, 104);
    step(3'b001, 3'b000, "bp regrant");
    set_req(0, G0, BF, 105);
    step(3'b000, 3'b000, "bp stall_after");
    req_data_ready = 3'b111;
    drain(10, "bp");

    // Reset one cycle after two grants: in-flight reads vanish, credits restored
    set_req(0, G0, BF, 110);
    set_req(1, G1, BF, 111);
    step(3'b011, 3'b000, "mid grant");
    clear_req();
    rst_p = 1'b1;
    set_req(0, G0, BF, 112);
    step(3'b000, 3'b000, "mid reset");
    rst_p = 1'b0;
    for (int r = 0; r < RN; r++) exp_q[r].delete();
    clear_req();
    for (int k = 0; k < 5; k++) idle_chk(3'b000, $sformatf("mid quiet%0d", k));
    req_data_ready = 3'b110;
    for (int k = 0; k < 4; k++) begin
      set_req(0, G0, BF, 120 + k);
      step(3'b001, 3'b000, $sformatf("mid credit%0d", k));
    end
    for (int k = 0; k < 2; k++) begin
      set_req(0, G0, BF, 130 + k);
      step(3'b000, 3'b000, $sformatf("mid full%0d", k));
    end
    req_data_ready = 3'b111;
    drain(10, "mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
